// File: rtl/sort_frame_ctrl_if.sv
// Control/status bundle between the sort-filter frame sequencer and its surroundings.
// master = stimulus/filter side driving strobes; slave = sequencer.
interface sort_frame_ctrl_if #(
    parameter int CW = 16
);
    logic          vsync;
    logic          din_valid;
    logic          dp_valid;
    logic          flush_line;
    logic [CW-1:0] in_line_cnt;
    logic [CW-1:0] out_pixel_cnt;
    logic [CW-1:0] out_line_cnt;
    logic          dout_valid;
    logic          is_border;
    logic          vsync_out;
    logic          frame_done;
    logic          err_overrun;

    modport master (
        output vsync, din_valid, dp_valid,
        input  flush_line, in_line_cnt, out_pixel_cnt, out_line_cnt,
        input  dout_valid, is_border, vsync_out, frame_done, err_overrun
    );

    modport slave (
        input  vsync, din_valid, dp_valid,
        output flush_line, in_line_cnt, out_pixel_cnt, out_line_cnt,
        output dout_valid, is_border, vsync_out, frame_done, err_overrun
    );
endinterface

// File: rtl/sort_frame_ctrl.sv
// Frame/line sequencer for the 2-D sort filter: counts input lines, injects R flush lines, tracks output coords.
// Latency: output path 1 cycle from dp_valid; no backpressure, protocol violations set sticky err_overrun.
module sort_frame_ctrl #(
    parameter int IW        = 640,
    parameter int IH        = 512,
    parameter int KSZ       = 3,
    parameter int FLUSH_GAP = 4,
    parameter int CW        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sort_frame_ctrl_if.slave     bus
);
    localparam int            R        = KSZ >> 1;
    localparam logic [CW-1:0] IW_LAST  = CW'(IW - 1);
    localparam logic [CW-1:0] IH_LAST  = CW'(IH - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(FLUSH_GAP - 1);
    localparam logic [CW-1:0] R_C      = CW'(R);
    localparam logic [CW-1:0] COL_HI   = CW'(IW - R);
    localparam logic [CW-1:0] ROW_HI   = CW'(IH - R);

    typedef enum logic [2:0] {IDLE, RECV, GAP, FLUSH, DRAIN} state_t;

    localparam state_t AFTER_RECV = (R == 0) ? DRAIN : GAP;

    state_t        state_q, state_d;
    logic          flush_d;
    logic          vsync_q;
    logic [CW-1:0] in_pix_q, in_line_q;
    logic [CW-1:0] gap_q, fl_pix_q, fl_line_q;
    logic [CW-1:0] col_q, row_q, out_col_q, out_row_q;
    logic          out_done_q, dout_valid_q, is_border_q, last_q, frame_done_q, err_q;

    logic in_eol, in_last, gap_end, fl_eol, fl_last, accept, at_last, border;

    assign in_eol  = bus.din_valid && (in_pix_q == IW_LAST);
    assign in_last = in_eol && (in_line_q == IH_LAST);
    assign gap_end = (gap_q == GAP_LAST);
    assign fl_eol  = (fl_pix_q == IW_LAST);
    assign fl_last = fl_eol && ((fl_line_q + CW'(1)) >= R_C);
    assign accept  = bus.dp_valid && !out_done_q;
    assign at_last = (col_q == IW_LAST) && (row_q == IH_LAST);
    assign border  = (col_q < R_C) || (col_q >= COL_HI) || (row_q < R_C) || (row_q >= ROW_HI);

    // A frame starts on the first low vsync edge after a high one; vsync_q marks that.
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        case (state_q)
            IDLE:  if (vsync_q && !bus.vsync) state_d = RECV;
            RECV:  if (in_last) state_d = AFTER_RECV;
            GAP:   if (gap_end) state_d = FLUSH;
            FLUSH: begin
                flush_d = 1'b1;
                if (fl_eol) state_d = fl_last ? DRAIN : GAP;
            end
            DRAIN: if (out_done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.vsync) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            in_pix_q     <= '0;
            in_line_q    <= '0;
            gap_q        <= '0;
            fl_pix_q     <= '0;
            fl_line_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            out_done_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            is_border_q  <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= bus.vsync;
            if (bus.vsync) begin
                in_pix_q     <= '0;
                in_line_q    <= '0;
                gap_q        <= '0;
                fl_pix_q     <= '0;
                fl_line_q    <= '0;
                col_q        <= '0;
                row_q        <= '0;
                out_col_q    <= '0;
                out_row_q    <= '0;
                out_done_q   <= 1'b0;
                dout_valid_q <= 1'b0;
                is_border_q  <= 1'b0;
                last_q       <= 1'b0;
                frame_done_q <= 1'b0;
                err_q        <= 1'b0;
            end else begin
                case (state_q)
                    RECV: if (bus.din_valid) begin
                        if (in_eol) begin
                            in_pix_q  <= '0;
                            in_line_q <= in_line_q + CW'(1);
                        end else begin
                            in_pix_q  <= in_pix_q + CW'(1);
                        end
                    end
                    GAP: gap_q <= gap_end ? '0 : gap_q + CW'(1);
                    FLUSH: begin
                        if (fl_eol) begin
                            fl_pix_q  <= '0;
                            fl_line_q <= fl_line_q + CW'(1);
                        end else begin
                            fl_pix_q  <= fl_pix_q + CW'(1);
                        end
                    end
                    default: ;
                endcase

                if ((bus.din_valid && state_q != RECV) || (bus.dp_valid && out_done_q))
                    err_q <= 1'b1;

                // Output side runs independently of the FSM so frame_done may fire mid-flush.
                dout_valid_q <= accept;
                is_border_q  <= accept && border;
                last_q       <= accept && at_last;
                frame_done_q <= last_q;
                if (accept) begin
                    out_col_q <= col_q;
                    out_row_q <= row_q;
                    if (col_q == IW_LAST) begin
                        col_q <= '0;
                        if (row_q == IH_LAST) out_done_q <= 1'b1;
                        else                  row_q      <= row_q + CW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
            end
        end
    end

    assign bus.flush_line    = flush_d;
    assign bus.in_line_cnt   = in_line_q;
    assign bus.out_pixel_cnt = out_col_q;
    assign bus.out_line_cnt  = out_row_q;
    assign bus.dout_valid    = dout_valid_q;
    assign bus.is_border     = is_border_q;
    assign bus.vsync_out     = vsync_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.err_overrun   = err_q;
endmodule
